softmax_normalize_block: RTL and testbench

- Back end of the softmax datapath. The downscale stage produces Zi - Zmax; exponentials are taken downstream of it; this block receives the resulting exponential stream.
- Buffers one frame of number_of_data non-negative exponentials and accumulates their sum.
- Then emits each probability Pi = Ei / sum as a fixed-point stream, in input order, using an iterative restoring divider.

---
 rtl/softmax_pkg.sv | 25 ++
 rtl/restoring_divider.sv | 93 +++++++++
 rtl/softmax_normalize_block.sv | 139 +++++++++++++
 tb/tb_softmax_normalize_block.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared widths, constants and state encoding for the softmax back end.
package softmax_pkg;

  localparam int DATA_SIZE      = 16;
  localparam int FRAC_SIZE      = 14;
  localparam int NUMBER_OF_DATA = 10;

  function automatic int sum_width(input int dw, input int n);
    return dw + $clog2(n);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SUM_SIZE = sum_width(DATA_SIZE, NUMBER_OF_DATA);
  localparam int ONE      = 1 << FRAC_SIZE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DIVIDE  = 2'd2
  } state_e;

endpackage

// File: rtl/restoring_divider.sv
// Fixed-latency fractional restoring divider: floor(dividend * 2^frac / divisor).
module restoring_divider
  import softmax_pkg::*;
#(
  parameter int data_size = DATA_SIZE,
  parameter int frac_size = FRAC_SIZE,
  parameter int sum_size  = SUM_SIZE
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [data_size-1:0] dividend,
  input  logic [sum_size-1:0]  divisor,
  output logic                 done_o,
  output logic [data_size-1:0] quotient_o
);

  localparam int rw = sum_size + 1;
  localparam int qw = frac_size + 1;
  localparam int cw = $clog2(frac_size + 1);
  localparam logic [data_size-1:0] SAT = data_size'(2 ** frac_size);
  localparam logic [cw-1:0] LAST_STEP = cw'(frac_size);

  logic [rw-1:0]       rem_q, rem_d;
  logic [sum_size-1:0] den_q, den_d;
  logic [qw-1:0]       quo_q, quo_d;
  logic [cw-1:0]       step_q, step_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic                sat_q, sat_d;
  logic                zero_q, zero_d;
  logic [rw-1:0]       shifted;
  logic                ge;

  always_comb begin
    rem_d   = rem_q;
    den_d   = den_q;
    quo_d   = quo_q;
    step_d  = step_q;
    run_d   = run_q;
    sat_d   = sat_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    // step 0 is the integer bit, so no shift before it
    shifted = (step_q == '0) ? rem_q : {rem_q[rw-2:0], 1'b0};
    ge      = shifted >= {1'b0, den_q};
    if (start_i) begin
      rem_d  = rw'(dividend);
      den_d  = divisor;
      quo_d  = '0;
      step_d = '0;
      run_d  = 1'b1;
      sat_d  = sum_size'(dividend) > divisor;
      zero_d = divisor == '0;
    end else if (run_q) begin
      rem_d  = ge ? shifted - {1'b0, den_q} : shifted;
      quo_d  = {quo_q[qw-2:0], ge};
      step_d = step_q + cw'(1);
      if (step_q == LAST_STEP) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
      step_q <= step_d;
      run_q  <= run_d;
      done_q <= done_d;
      sat_q  <= sat_d;
      zero_q <= zero_d;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = zero_q ? '0 :
                      sat_q  ? SAT :
                      data_size'(quo_q);

endmodule

// File: rtl/softmax_normalize_block.sv
// Buffers a frame of exponentials, sums them, then streams Ei / sum.
module softmax_normalize_block
  import softmax_pkg::*;
#(
  parameter int data_size      = DATA_SIZE,
  parameter int frac_size      = FRAC_SIZE,
  parameter int number_of_data = NUMBER_OF_DATA
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 valid_i,
  input  logic [data_size-1:0] data_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [data_size-1:0] data_o,
  output logic                 done_o
);

  localparam int sum_size = sum_width(data_size, number_of_data);
  localparam int iw       = idx_width(number_of_data);
  localparam logic [iw-1:0] LAST = iw'(number_of_data - 1);

  state_e               state_q, state_d;
  logic [iw-1:0]        count_q, count_d;
  logic [iw-1:0]        index_q, index_d;
  logic [sum_size-1:0]  sum_q, sum_d;
  logic [data_size-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic [data_size-1:0] buf_q [number_of_data];

  logic                 wr_en;
  logic                 div_start;
  logic [data_size-1:0] div_dividend;
  logic [sum_size-1:0]  div_divisor;
  logic                 div_done;
  logic [data_size-1:0] div_quot;

  restoring_divider #(
    .data_size (data_size),
    .frac_size (frac_size),
    .sum_size  (sum_size)
  ) u_div (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .start_i    (div_start),
    .dividend   (div_dividend),
    .divisor    (div_divisor),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    index_d      = index_q;
    sum_d        = sum_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    wr_en        = 1'b0;
    div_start    = 1'b0;
    div_dividend = buf_q[index_q];
    div_divisor  = sum_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = COLLECT;
          count_d = '0;
          sum_d   = '0;
        end
      end
      COLLECT: begin
        if (valid_i) begin
          wr_en   = 1'b1;
          sum_d   = sum_q + sum_size'(data_i);
          count_d = count_q + iw'(1);
          if (count_q == LAST) begin
            // element 0 is still on data_i when the frame holds one item
            state_d      = DIVIDE;
            count_d      = '0;
            index_d      = '0;
            div_start    = 1'b1;
            div_dividend = (count_q == '0) ? data_i : buf_q[0];
            div_divisor  = sum_d;
          end
        end
      end
      DIVIDE: begin
        if (done_q) begin
          state_d = IDLE;
          index_d = '0;
        end else if (div_done) begin
          data_d  = div_quot;
          valid_d = 1'b1;
          if (index_q == LAST) begin
            done_d = 1'b1;
          end else begin
            index_d      = index_q + iw'(1);
            div_start    = 1'b1;
            div_dividend = buf_q[index_d];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
      sum_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (wr_en) buf_q[count_q] <= data_i;
  end

  assign busy_o  = state_q != IDLE;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_softmax_normalize_block.sv
// Randomized self-checking bench against an arithmetic softmax model.
module tb_softmax_normalize_block;

  localparam int DW = 16;
  localparam int FW = 14;
  localparam int N  = 4;
  localparam int SW = 18;
  localparam int L  = FW + 2;
  localparam int ONE_V = 1 << FW;

  typedef int frame_t [N];

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          busy_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          done_o;

  logic          d_start;
  logic [DW-1:0] d_dividend;
  logic [SW-1:0] d_divisor;
  logic          d_done;
  logic [DW-1:0] d_quot;

  softmax_normalize_block #(
    .data_size      (DW),
    .frac_size      (FW),
    .number_of_data (N)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .done_o  (done_o)
  );

  restoring_divider #(
    .data_size (DW),
    .frac_size (FW),
    .sum_size  (SW)
  ) div_dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .start_i    (d_start),
    .dividend   (d_dividend),
    .divisor    (d_divisor),
    .done_o     (d_done),
    .quotient_o (d_quot)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int got_data [N];
  int got_off  [N];
  int got_done [N];
  int ngot;
  int busy_after;
  int entry;

  function automatic int model_q(input longint e, input longint s);
    if (s == 0) return 0;
    if (e > s) return ONE_V;
    return int'((e * ONE_V) / s);
  endfunction

  function automatic longint frame_sum(input frame_t f);
    longint s = 0;
    for (int i = 0; i < N; i++) s += f[i];
    return s;
  endfunction

  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive_frame(input frame_t f, input int gap, input bit noise);
    valid_i = noise;
    data_i  = DW'($urandom);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    valid_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap; g++) begin
        start_i = noise;
        tick();
        start_i = 1'b0;
      end
      valid_i = 1'b1;
      data_i  = DW'(f[i]);
      tick();
      valid_i = 1'b0;
    end
    entry = cyc;
  endtask

  task automatic collect(input bit noise);
    ngot = 0;
    busy_after = -1;
    for (int k = 1; k <= N * L + 8 && ngot < N; k++) begin
      if (noise) begin
        valid_i = 1'($urandom_range(0, 1));
        data_i  = DW'($urandom);
        start_i = 1'($urandom_range(0, 1));
      end
      tick();
      if (valid_o) begin
        got_data[ngot] = int'(data_o);
        got_off[ngot]  = cyc - entry;
        got_done[ngot] = int'(done_o);
        ngot++;
      end
    end
    valid_i = 1'b0;
    start_i = 1'b0;
    if (ngot == N) begin
      tick();
      busy_after = int'(busy_o);
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    start_i = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    d_start = 1'b0;
    d_dividend = '0;
    d_divisor  = '0;
    repeat (3) tick();
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b expected 0", busy_o);
    end
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b expected 0", valid_o);
    end
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_done: got %b expected 0", done_o);
    end
    n_cmp++;
    if (data_o !== '0) begin
      n_bad++; $display("FAIL reset_data: got %0d expected 0", data_o);
    end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_frame(input string name, input frame_t f,
                            input int gap, input bit noise);
    longint s;
    int exp_v;
    s = frame_sum(f);
    drive_frame(f, gap, noise);
    collect(noise);
    n_cmp++;
    if (ngot != N) begin
      n_bad++;
      $display("FAIL %s count: got %0d outputs expected %0d", name, ngot, N);
    end
    for (int i = 0; i < ngot; i++) begin
      exp_v = model_q(f[i], s);
      n_cmp++;
      if (got_data[i] !== exp_v) begin
        n_bad++;
        $display("FAIL %s data[%0d]: got %0d expected %0d (E=%0d sum=%0d)",
                 name, i, got_data[i], exp_v, f[i], s);
      end
      n_cmp++;
      if (got_off[i] !== (i + 1) * L) begin
        n_bad++;
        $display("FAIL %s timing[%0d]: got %0d expected %0d",
                 name, i, got_off[i], (i + 1) * L);
      end
      n_cmp++;
      if (got_done[i] !== int'(i == N - 1)) begin
        n_bad++;
        $display("FAIL %s done[%0d]: got %0d expected %0d",
                 name, i, got_done[i], int'(i == N - 1));
      end
    end
    if (ngot == N) begin
      n_cmp++;
      if (busy_after !== 0) begin
        n_bad++;
        $display("FAIL %s busy_after: got %0d expected 0", name, busy_after);
      end
    end
  endtask

  task automatic test_reset_mid;
    frame_t u = '{16384, 16384, 16384, 16384};
    int pulses;
    drive_frame(u, 0, 1'b0);
    repeat (L + 6) tick();
    reset_i = 1'b1;
    tick();
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++; $display("FAIL midreset_busy: got %b expected 0", busy_o);
    end
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_bad++; $display("FAIL midreset_valid: got %b expected 0", valid_o);
    end
    n_cmp++;
    if (data_o !== '0) begin
      n_bad++; $display("FAIL midreset_data: got %0d expected 0", data_o);
    end
    reset_i = 1'b0;
    pulses = 0;
    for (int k = 0; k < 3 * L; k++) begin
      valid_i = 1'b1;
      data_i  = DW'($urandom);
      tick();
      if (valid_o || busy_o) pulses++;
    end
    valid_i = 1'b0;
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL midreset_idle: got %0d active cycles expected 0", pulses);
    end
    test_frame("post_reset", u, 0, 1'b0);
  endtask

  task automatic test_divider;
    int a, b, exp_v, lat;
    for (int t = 0; t < 8; t++) begin
      if (t == 0) begin
        a = 5; b = 3;
      end else if (t == 1) begin
        a = 1234; b = 0;
      end else if (t < 5) begin
        b = int'($urandom_range(1, 20000));
        a = int'($urandom_range(b + 1, 65535));
      end else begin
        b = int'($urandom_range(1, (1 << SW) - 1));
        a = int'($urandom_range(0, (b < 65535) ? b : 65535));
      end
      exp_v = model_q(a, b);
      d_dividend = DW'(a);
      d_divisor  = SW'(b);
      d_start = 1'b1;
      tick();
      d_start = 1'b0;
      lat = 1;
      while (!d_done && lat < 3 * L) begin
        tick();
        lat++;
      end
      n_cmp++;
      if (lat !== L) begin
        n_bad++;
        $display("FAIL div_latency[%0d]: got %0d expected %0d", t, lat, L);
      end
      n_cmp++;
      if (int'(d_quot) !== exp_v) begin
        n_bad++;
        $display("FAIL div_quot[%0d]: got %0d expected %0d (a=%0d b=%0d)",
                 t, d_quot, exp_v, a, b);
      end
      tick();
    end
  endtask

  initial begin
    frame_t f;
    test_reset();
    f = '{16384, 16384, 16384, 16384};
    test_frame("uniform", f, 0, 1'b0);
    f = '{16384, 8192, 8192, 0};
    test_frame("mixed", f, 2, 1'b0);
    f = '{16384, 16384, 16384, 1};
    test_frame("rounding", f, 0, 1'b0);
    f = '{0, 0, 0, 0};
    test_frame("zero", f, 1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) f[i] = int'($urandom_range(0, 65535));
      test_frame("random", f, int'($urandom_range(0, 3)), 1'b0);
    end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) f[i] = int'($urandom_range(0, 65535));
      test_frame("ignored", f, 1, 1'b1);
    end
    test_reset_mid();
    test_divider();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
